mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port round-robin arbiter that shares the single DDR block interface (28-bit block address, 256-bit data, `mem_valid`/`mem_ready` handshake) between the instruction-cache controller (port 0) and the data-cache controller (port 1). Each cache controller connects its `mem_*` outputs to a requester port unchanged. The arbiter registers the winning request, runs exactly one DDR transaction, and returns read data and a one-cycle ready pulse to the winner. A per-port lock keeps back-to-back transactions, such as a 1024-block flush, on one port.

## Interface
- ADDR_WIDTH, 28, block address width
- BLOCK_SIZE, 256, data width of one block transfer in bits
- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  2  per-port request; held high until that port's req_ready
- req_rw  in  2  per-port direction: 1 = write (write-back), 0 = read (allocate)
- req_lock  in  2  per-port lock: keep the grant across consecutive transactions
- req_addr0, req_addr1  in  ADDR_WIDTH  per-port block address
- req_wr0, req_wr1  in  BLOCK_SIZE  per-port write data
- req_ready  out  2  per-port one-cycle completion pulse
- req_rd  out  BLOCK_SIZE  read data; valid while req_ready is high, shared by both ports
- grant  out  2  one-hot owner of the current transaction; 0 when IDLE
- mem_addr  out  ADDR_WIDTH  DDR address
- mem_wr  out  BLOCK_SIZE  DDR write data
- mem_rw  out  1  DDR direction
- mem_valid  out  1  DDR request
- mem_rd  in  BLOCK_SIZE  DDR read data
- mem_ready  in  1  DDR one-cycle completion pulse

## Operation
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - If any req_valid is high, select a winner. Latch its addr, wr and rw into the request registers. Set grant and go to BUSY.
  - Otherwise stay in IDLE.
- Winner selection, in priority order:
  1. If `last` (the port granted most recently) has req_lock and req_valid high, `last` wins.
  2. Otherwise, if only one port is valid, that port wins.
  3. If both ports are valid, the port other than `last` wins.
- `last` updates to the winner whenever a grant is made. It resets to 1, so port 0 wins the first tie.
- BUSY:
  - mem_valid = 1. mem_addr, mem_wr and mem_rw come from the request registers, never directly from the requester inputs.
  - On mem_ready, capture mem_rd into req_rd and go to RESP.
- RESP:
  - req_ready[winner] = 1 for exactly this cycle. mem_valid = 0.
  - req_valid is ignored. Next state is IDLE.
- mem_wr is driven as 0 when mem_rw = 0.
- For write transactions, req_rd still captures mem_rd (don't-care for the requester).
- While BUSY, a change on any requester input has no effect on mem_* outputs.
- grant stays set through BUSY and RESP and clears on return to IDLE.

## Timing
- Reset (asynchronous, takes effect immediately, including mid-transaction):
  - state = IDLE, last = 1.
  - Request registers and req_rd = 0.
  - Outputs: req_ready = 0, grant = 0, mem_valid = 0, mem_rw = 0, mem_addr = 0, mem_wr = 0.
  - No DDR completion is delivered for an aborted transaction.
- Cycle-level sequence:
  - Request first seen high in IDLE at cycle t.
  - mem_valid high from cycle t+1.
  - mem_ready arrives at cycle n (n ≥ t+1).
  - req_ready and req_rd valid at cycle n+1.
  - Back in IDLE at n+2.
- Minimum cost: 3 cycles per transaction. Maximum throughput: one transaction per 3 cycles plus memory latency.
- A requester must drop req_valid in the cycle after req_ready, or present a new request.
- A new request presented at n+2 is arbitrated in that IDLE cycle.
- mem_valid drops in the cycle immediately after mem_ready and never stays high across two transactions.
- A mem_ready pulse while in IDLE or RESP is ignored.
- Port 0 and port 1 both asserting req_valid in the same cycle is resolved by the round-robin rule; the loser waits with no lost request.
- A locked port can starve the other port indefinitely; this is intended for flush.

## Test plan
- Single read:
  - Stimulus: reset; port 0 valid, rw = 0, addr = 28'h0001238; memory returns mem_ready 4 cycles after mem_valid with mem_rd = {8{32'hDEADBEEF}}.
  - Required: mem_addr = 28'h0001238 and mem_rw = 0 from cycle 1; req_ready = 2'b01 with req_rd = {8{32'hDEADBEEF}} exactly one cycle after mem_ready; grant = 0 the next cycle.
- Single write:
  - Stimulus: port 1, rw = 1, addr = 28'h0FFFFF8, wr = {8{32'hA5A5A5A5}}.
  - Required: mem_rw = 1 and mem_wr equal to the written data throughout BUSY; req_ready = 2'b10 pulse of one cycle; mem_valid = 0 in RESP.
- Simultaneous requests:
  - Stimulus: after reset, both ports valid continuously.
  - Required: grants alternate 01, 10, 01, 10; each port gets exactly one req_ready per transaction.
- Lock:
  - Stimulus: port 1 holds req_lock = 1 and valid for 5 transactions while port 0 is valid.
  - Required: all 5 grants go to port 1; port 0 is granted immediately after port 1 drops lock.
- Input stability:
  - Stimulus: port 0 changes req_addr0 to 28'h0000008 mid-BUSY.
  - Required: mem_addr keeps the originally latched value until mem_ready.
- Reset mid-transaction:
  - Stimulus: assert rst during BUSY, then deliver mem_ready after rst is released.
  - Required: mem_valid, grant and req_ready go to 0 immediately; the stray mem_ready is ignored; the first tie after reset goes to port 0.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter for the shared DDR block interface.
// Each grant latches one request and runs a single DDR transaction. The winner then gets a one-cycle ready pulse.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 28,
  parameter int BLOCK_SIZE = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  input  logic [1:0]            req_rw,
  input  logic [1:0]            req_lock,
  input  logic [ADDR_WIDTH-1:0] req_addr0,
  input  logic [ADDR_WIDTH-1:0] req_addr1,
  input  logic [BLOCK_SIZE-1:0] req_wr0,
  input  logic [BLOCK_SIZE-1:0] req_wr1,
  output logic [1:0]            req_ready,
  output logic [BLOCK_SIZE-1:0] req_rd,
  output logic [1:0]            grant,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [BLOCK_SIZE-1:0] mem_wr,
  output logic                  mem_rw,
  output logic                  mem_valid,
  input  logic [BLOCK_SIZE-1:0] mem_rd,
  input  logic                  mem_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t                state_q, state_d;
  logic                  last_q, last_d;
  logic [1:0]            grant_q, grant_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [BLOCK_SIZE-1:0] wr_q, wr_d;
  logic                  rw_q, rw_d;
  logic [BLOCK_SIZE-1:0] rd_q, rd_d;
  logic                  win;

  // A locked previous owner keeps the grant. Otherwise a lone requester wins, and a tie goes to the port that was not granted last.
  always_comb begin
    win = ~last_q;
    if (req_valid[last_q] && req_lock[last_q]) win = last_q;
    else if (req_valid == 2'b01)               win = 1'b0;
    else if (req_valid == 2'b10)               win = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      grant_q <= '0;
      addr_q  <= '0;
      wr_q    <= '0;
      rw_q    <= 1'b0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      addr_q  <= addr_d;
      wr_q    <= wr_d;
      rw_q    <= rw_d;
      rd_q    <= rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    grant_d = grant_q;
    addr_d  = addr_q;
    wr_d    = wr_q;
    rw_d    = rw_q;
    rd_d    = rd_q;
    unique case (state_q)
      IDLE: begin
        if (|req_valid) begin
          state_d = BUSY;
          last_d  = win;
          grant_d = win ? 2'b10 : 2'b01;
          addr_d  = win ? req_addr1 : req_addr0;
          wr_d    = win ? req_wr1 : req_wr0;
          rw_d    = req_rw[win];
        end
      end
      BUSY: begin
        if (mem_ready) begin
          rd_d    = mem_rd;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // DDR side is driven only from the latched request, never from live requester inputs.
  assign mem_valid = (state_q == BUSY);
  assign mem_addr  = addr_q;
  assign mem_rw    = rw_q;
  assign mem_wr    = rw_q ? wr_q : '0;
  assign grant     = grant_q;
  assign req_ready = (state_q == RESP) ? grant_q : 2'b00;
  assign req_rd    = rd_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboarded bench for mem_arbiter. A behavioral DDR model returns address-derived data.
module tb_mem_arbiter;

  typedef struct {
    logic [1:0]   g;
    logic [255:0] d;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   req_valid, req_rw, req_lock, req_ready, grant;
  logic [27:0]  req_addr0, req_addr1, mem_addr;
  logic [255:0] req_wr0, req_wr1, req_rd, mem_wr, mem_rd;
  logic         mem_rw, mem_valid, mem_ready;

  logic         pv[2], prw[2], plk[2];
  logic [27:0]  pa[2];
  logic [255:0] pw[2];

  exp_t sb[$];
  int   n_chk = 0, n_err = 0;
  int   lat = 4;
  bit   mem_en = 1'b1;
  int   stray_cnt = 0, stray_done = 0;

  assign req_valid = {pv[1], pv[0]};
  assign req_rw    = {prw[1], prw[0]};
  assign req_lock  = {plk[1], plk[0]};
  assign req_addr0 = pa[0];
  assign req_addr1 = pa[1];
  assign req_wr0   = pw[0];
  assign req_wr1   = pw[1];

  mem_arbiter #(.ADDR_WIDTH(28), .BLOCK_SIZE(256)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_rw(req_rw), .req_lock(req_lock),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wr0(req_wr0), .req_wr1(req_wr1),
    .req_ready(req_ready), .req_rd(req_rd), .grant(grant),
    .mem_addr(mem_addr), .mem_wr(mem_wr), .mem_rw(mem_rw), .mem_valid(mem_valid),
    .mem_rd(mem_rd), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] mk(input logic [27:0] a);
    return {8{32'hDEADBEEF ^ {4'h0, a ^ 28'h0001238}}};
  endfunction

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic push(input int p, input logic [27:0] a);
    exp_t e;
    e.g = (p == 0) ? 2'b01 : 2'b10;
    e.d = mk(a);
    sb.push_back(e);
  endtask

  // DDR model: answers lat cycles after it first sees mem_valid; can also emit a stray ready pulse.
  initial begin
    mem_ready = 1'b0;
    mem_rd    = '0;
    forever begin
      @(negedge clk);
      if (mem_valid && mem_en) begin
        repeat (lat) @(negedge clk);
        mem_rd    = mk(mem_addr);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
      end else if (stray_cnt != stray_done) begin
        mem_rd    = '1;
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        stray_done++;
      end
    end
  end

  // Scoreboard: every ready pulse must match the oldest expected completion.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && req_ready != 2'b00) begin
        if (sb.size() == 0) chk("unexpected_ready", 256'(req_ready), 256'd0);
        else begin
          e = sb.pop_front();
          chk("sb_ready", 256'(req_ready), 256'(e.g));
          chk("sb_grant", 256'(grant), 256'(e.g));
          chk("sb_rd", req_rd, e.d);
        end
      end
    end
  end

  task automatic single_txn(input int p, input logic rw, input logic [27:0] a,
                            input logic [255:0] wd, input bit perturb);
    logic [1:0] g;
    int n;
    g = (p == 0) ? 2'b01 : 2'b10;
    push(p, a);
    pv[p] = 1'b1; prw[p] = rw; pa[p] = a; pw[p] = wd; plk[p] = 1'b0;
    @(negedge clk);
    chk("busy_valid", 256'(mem_valid), 256'd1);
    chk("busy_grant", 256'(grant), 256'(g));
    chk("busy_addr", 256'(mem_addr), 256'(a));
    chk("busy_rw", 256'(mem_rw), 256'(rw));
    chk("busy_wr", mem_wr, rw ? wd : 256'd0);
    if (perturb) begin
      pa[p] = 28'h0000008; pw[p] = ~wd; prw[p] = ~rw;
    end
    n = 0;
    while (req_ready == 2'b00 && n < 50) begin
      @(negedge clk);
      n++;
      if (req_ready == 2'b00) begin
        chk("hold_valid", 256'(mem_valid), 256'd1);
        chk("hold_addr", 256'(mem_addr), 256'(a));
        chk("hold_rw", 256'(mem_rw), 256'(rw));
        chk("hold_wr", mem_wr, rw ? wd : 256'd0);
      end
    end
    chk("latency", 256'(n), 256'(lat + 1));
    chk("resp_mem_valid", 256'(mem_valid), 256'd0);
    pv[p] = 1'b0;
    @(negedge clk);
    chk("idle_grant", 256'(grant), 256'd0);
    chk("ready_pulse", 256'(req_ready), 256'd0);
  endtask

  task automatic drive_port(input int p, input int n, input logic [27:0] base,
                            input logic rw, input logic lk);
    int w;
    for (int i = 0; i < n; i++) begin
      pv[p] = 1'b1; prw[p] = rw; plk[p] = lk;
      pa[p] = base + 28'(i * 8);
      pw[p] = {8{32'(i) ^ 32'h5A5A0000}};
      w = 0;
      do begin
        @(negedge clk);
        w++;
      end while (!req_ready[p] && w < 200);
      if (w >= 200) begin
        chk("drv_timeout", 256'd0, 256'd1);
        break;
      end
    end
    pv[p] = 1'b0; plk[p] = 1'b0;
  endtask

  task automatic pulse_rst();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    for (int i = 0; i < 2; i++) begin
      pv[i] = 1'b0; prw[i] = 1'b0; plk[i] = 1'b0; pa[i] = '0; pw[i] = '0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", 256'(req_ready), 256'd0);
    chk("rst_grant", 256'(grant), 256'd0);
    chk("rst_mem_valid", 256'(mem_valid), 256'd0);
    chk("rst_mem_rw", 256'(mem_rw), 256'd0);
    chk("rst_mem_addr", 256'(mem_addr), 256'd0);
    chk("rst_mem_wr", mem_wr, 256'd0);
    chk("rst_req_rd", req_rd, 256'd0);
    rst = 1'b0;
    @(negedge clk);

    lat = 4;
    single_txn(0, 1'b0, 28'h0001238, 256'd0, 1'b0);
    single_txn(1, 1'b1, 28'h0FFFFF8, {8{32'hA5A5A5A5}}, 1'b0);
    lat = 6;
    single_txn(0, 1'b0, 28'h0000100, {8{32'h12345678}}, 1'b1);

    lat = 1;
    pulse_rst();
    push(0, 28'h10); push(1, 28'h20); push(0, 28'h18); push(1, 28'h28);
    fork
      drive_port(0, 2, 28'h10, 1'b0, 1'b0);
      drive_port(1, 2, 28'h20, 1'b1, 1'b0);
    join

    pulse_rst();
    for (int i = 0; i < 5; i++) push(1, 28'h800 + 28'(i * 8));
    push(0, 28'h400);
    fork
      drive_port(0, 1, 28'h400, 1'b0, 1'b0);
      drive_port(1, 5, 28'h800, 1'b1, 1'b1);
    join

    @(negedge clk);
    mem_en = 1'b0;
    pv[0] = 1'b1; prw[0] = 1'b0; pa[0] = 28'h0000ABC;
    repeat (2) @(negedge clk);
    chk("abort_busy", 256'(mem_valid), 256'd1);
    rst = 1'b1;
    #1;
    chk("abort_mem_valid", 256'(mem_valid), 256'd0);
    chk("abort_grant", 256'(grant), 256'd0);
    chk("abort_ready", 256'(req_ready), 256'd0);
    chk("abort_mem_addr", 256'(mem_addr), 256'd0);
    pv[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    stray_cnt++;
    n = 0;
    while (stray_done != stray_cnt && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stray_delivered", 256'(stray_done), 256'(stray_cnt));
    @(negedge clk);
    chk("stray_mem_valid", 256'(mem_valid), 256'd0);
    chk("stray_ready", 256'(req_ready), 256'd0);
    chk("stray_grant", 256'(grant), 256'd0);

    mem_en = 1'b1;
    push(0, 28'h30); push(1, 28'h40);
    fork
      drive_port(0, 1, 28'h30, 1'b0, 1'b0);
      drive_port(1, 1, 28'h40, 1'b0, 1'b0);
    join

    repeat (3) @(negedge clk);
    chk("sb_drained", 256'(sb.size()), 256'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
